// File: rtl/osc_meas_pkg.sv
// Shared definitions for the oscillator measurement controller:
// FSM state encoding, register offsets and CTRL/STATUS bit positions.
package osc_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_STORE  = 3'd3,
    ST_NEXT   = 3'd4
  } state_t;

  // Register offsets, decoded from wbs_adr_i[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_GATE    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_RESULT0 = 3'd3;
  localparam logic [2:0] REG_RESULT1 = 3'd4;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_MASK_LO = 2;
  localparam int CTRL_MASK_HI = 3;
  localparam int CTRL_IRQ_EN  = 4;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE_LO = 1;
  localparam int STAT_DONE_HI = 2;
  localparam int STAT_OVF_LO  = 3;
  localparam int STAT_OVF_HI  = 4;

  // One-hot enable for the selected channel
  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/osc_meas_ctrl_edge_sync.sv
// Two-flop synchronizer followed by an edge flop for one asynchronous
// oscillator input. 'rise' is a single-cycle pulse per synchronized rising edge.
module osc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic osc,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Resynchronize the oscillator and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= osc;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/osc_meas_ctrl.sv
// Two-channel ring-oscillator frequency measurement controller with a
// Wishbone slave register interface. Each masked channel is enabled, allowed
// to settle, then its rising edges are counted over a programmable gate.
// Optional feature: define OSC_MEAS_IRQ_EN to add the level interrupt irq_o
// (irq_en & |done); without it CTRL[4] reads 0 and there is no irq_o port.
// Counts are only meaningful for oscillator frequencies below half wb_clk_i.
module osc_meas_ctrl
  import osc_meas_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int SETTLE_CYC = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [1:0]  osc_out_i,
  output logic [1:0]  osc_en_o,
  output logic        busy_o
`ifdef OSC_MEAS_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]      SETTLE_LAST = (SETTLE_CYC > 0) ? 32'(SETTLE_CYC - 1) : 32'd0;

  state_t            state;
  state_t            state_nxt;
  logic              cur_ch;
  logic              ch_nxt;
  logic [31:0]       timer;
  logic [15:0]       gate_lat;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  result0;
  logic [CNT_W-1:0]  result1;
  logic [1:0]        done;
  logic [1:0]        ovf;
  logic [1:0]        done_set;
  logic [1:0]        ovf_set;
  logic [1:0]        done_clr;
  logic [1:0]        ovf_clr;
  logic              ctrl_cont;
  logic [1:0]        ctrl_mask;
  logic              ctrl_irq_en;
  logic [15:0]       gate_len;
  logic [1:0]        rise;
  logic              rise_sel;
  logic              access;
  logic              wr_en;
  logic [2:0]        reg_sel;
  logic              start_req;
  logic [1:0]        start_mask;
  logic              measuring;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign access     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_en      = access & wbs_we_i;
  assign reg_sel    = wbs_adr_i[4:2];
  assign start_req  = wr_en && (reg_sel == REG_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
  assign start_mask = wbs_dat_i[CTRL_MASK_HI:CTRL_MASK_LO];
  assign done_clr   = (wr_en && (reg_sel == REG_STATUS) && wbs_sel_i[0]) ?
                      wbs_dat_i[STAT_DONE_HI:STAT_DONE_LO] : 2'b00;
  assign ovf_clr    = (wr_en && (reg_sel == REG_STATUS) && wbs_sel_i[0]) ?
                      wbs_dat_i[STAT_OVF_HI:STAT_OVF_LO] : 2'b00;
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  osc_edge_sync u_sync0 (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .osc   (osc_out_i[0]),
    .rise  (rise[0])
  );

  osc_edge_sync u_sync1 (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .osc   (osc_out_i[1]),
    .rise  (rise[1])
  );

  assign rise_sel  = rise[cur_ch];
  assign measuring = (state == ST_SETTLE) || (state == ST_GATE) || (state == ST_STORE);
  // Derived from registered state only, so an async reset drops the enable at once
  assign osc_en_o  = measuring ? ch_onehot(cur_ch) : 2'b00;
  assign busy_o    = (state != ST_IDLE);

`ifdef OSC_MEAS_IRQ_EN
  assign irq_o = ctrl_irq_en & (|done);
`else
  assign ctrl_irq_en = 1'b0;
`endif

  // State and active-channel register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= ST_IDLE;
      cur_ch <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur_ch <= ch_nxt;
    end
  end

  // Next-state logic; channels are visited 0 then 1 among the live mask
  always_comb begin
    state_nxt = state;
    ch_nxt    = cur_ch;
    case (state)
      ST_IDLE: begin
        if (start_req && (start_mask != 2'b00)) begin
          state_nxt = ST_SETTLE;
          ch_nxt    = ~start_mask[0];
        end
      end
      ST_SETTLE: begin
        if (timer == SETTLE_LAST) state_nxt = ST_GATE;
      end
      ST_GATE: begin
        if (timer == (32'(gate_lat) - 32'd1)) state_nxt = ST_STORE;
      end
      ST_STORE: begin
        state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (!cur_ch && ctrl_mask[1]) begin
          state_nxt = ST_SETTLE;
          ch_nxt    = 1'b1;
        end else if (ctrl_cont && (ctrl_mask != 2'b00)) begin
          state_nxt = ST_SETTLE;
          ch_nxt    = ~ctrl_mask[0];
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase timer restarts on every state change
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      timer <= 32'd0;
    end else if (state_nxt != state) begin
      timer <= 32'd0;
    end else if ((state == ST_SETTLE) || (state == ST_GATE)) begin
      timer <= timer + 32'd1;
    end
  end

  // Gate length is captured and the edge counter cleared on GATE entry; counter saturates
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt      <= '0;
      gate_lat <= 16'd0;
    end else if ((state == ST_SETTLE) && (state_nxt == ST_GATE)) begin
      cnt      <= '0;
      gate_lat <= (gate_len == 16'd0) ? 16'd1 : gate_len;
    end else if ((state == ST_GATE) && rise_sel && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done_set = (state == ST_STORE) ? ch_onehot(cur_ch) : 2'b00;
  assign ovf_set  = ((state == ST_STORE) && (cnt == CNT_MAX)) ? ch_onehot(cur_ch) : 2'b00;

  // Results and sticky status flags; a set in STORE beats a simultaneous clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      result0 <= '0;
      result1 <= '0;
      done    <= 2'b00;
      ovf     <= 2'b00;
    end else begin
      done <= (done & ~done_clr) | done_set;
      ovf  <= (ovf & ~ovf_clr) | ovf_set;
      if (state == ST_STORE) begin
        if (cur_ch) result1 <= cnt;
        else        result0 <= cnt;
      end
    end
  end

  // Writable configuration registers with per-byte enables
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_cont <= 1'b0;
      ctrl_mask <= 2'b00;
      gate_len  <= 16'd0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          if (wbs_sel_i[0]) begin
            ctrl_cont <= wbs_dat_i[CTRL_CONT];
            ctrl_mask <= wbs_dat_i[CTRL_MASK_HI:CTRL_MASK_LO];
          end
        end
        REG_GATE: begin
          if (wbs_sel_i[0]) gate_len[7:0]  <= wbs_dat_i[7:0];
          if (wbs_sel_i[1]) gate_len[15:8] <= wbs_dat_i[15:8];
        end
        default: ;
      endcase
    end
  end

`ifdef OSC_MEAS_IRQ_EN
  // Interrupt enable lives in CTRL byte 0 alongside the other control bits
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_irq_en <= 1'b0;
    end else if (wr_en && (reg_sel == REG_CTRL) && wbs_sel_i[0]) begin
      ctrl_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
    end
  end
`endif

  // Read multiplexer; unmapped offsets return zero
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_CONT]                 = ctrl_cont;
        rd_data[CTRL_MASK_HI:CTRL_MASK_LO] = ctrl_mask;
        rd_data[CTRL_IRQ_EN]               = ctrl_irq_en;
      end
      REG_GATE:    rd_data[15:0] = gate_len;
      REG_STATUS: begin
        rd_data[STAT_BUSY]                 = busy_o;
        rd_data[STAT_DONE_HI:STAT_DONE_LO] = done;
        rd_data[STAT_OVF_HI:STAT_OVF_LO]   = ovf;
      end
      REG_RESULT0: rd_data[CNT_W-1:0] = result0;
      REG_RESULT1: rd_data[CNT_W-1:0] = result1;
      default: ;
    endcase
  end

  // Single-cycle ack one clock after cyc&stb; the ack itself blocks a back-to-back ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_data : 32'd0;
    end
  end

endmodule
